// File: rtl/cel_src_bit_reader.sv
// Source-word fetcher for the cel pixel decoder: prefetches packed 32-bit words
// into a small FIFO and serves MSB-first bit fields of 1..16 bits from a 64-bit buffer.
module cel_src_bit_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [15:0]             word_count,
    output logic                    busy,
    output logic                    error,
    input  logic [4:0]              field_width,
    input  logic                    field_req,
    output logic                    field_ready,
    output logic [15:0]             field_data,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    input  logic                    mem_rsp_error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           total_q;
    logic [15:0]           issued_q;
    logic [15:0]           issued_nxt;
    logic [CW-1:0]         outst_q;
    logic [CW-1:0]         outst_nxt;
    logic                  req_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  error_nxt;
    logic                  latch_run;

    logic                  gnt_fire;
    logic                  rsp_fire;
    logic                  rsp_take;
    logic                  push;
    logic                  rsp_err;
    logic                  hold_req;
    logic                  clear_bufs;
    logic [OW-1:0]         occ;
    logic                  slots_ok;

    logic [DATA_WIDTH-1:0] fifo_mem_p0 [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_p0;
    logic [PW-1:0]         rd_ptr_p0;
    logic [CW-1:0]         fifo_cnt_p0;
    logic [CW-1:0]         fifo_cnt_nxt;

    logic [63:0]           bitbuf_p1;
    logic [6:0]            bitcnt_p1;
    logic [63:0]           buf_after;
    logic [63:0]           buf_nxt;
    logic [6:0]            cnt_after;
    logic [6:0]            cnt_nxt;
    logic [DATA_WIDTH-1:0] load_word;
    logic                  load;
    logic                  consume;
    logic                  vld_p1;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [15:0]           idx);
        return base + {{(ADDR_WIDTH-18){1'b0}}, idx, 2'b00};
    endfunction

    function automatic logic [15:0] extract_field(input logic [15:0] top, input logic [4:0] w);
        if (w == 5'd0 || w > 5'd16)
            return 16'd0;
        return top >> (5'd16 - w);
    endfunction

    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
    assign mem_be    = {(DATA_WIDTH/8){mem_req}};
    assign busy      = (state != ST_IDLE);

    assign gnt_fire   = mem_req && mem_gnt;
    assign rsp_fire   = mem_rsp_valid && (outst_q != '0);
    assign rsp_take   = rsp_fire && (state == ST_FETCH) && !flush;
    assign push       = rsp_take && !mem_rsp_error;
    assign rsp_err    = rsp_take && mem_rsp_error;
    assign hold_req   = mem_req && !mem_gnt;
    assign clear_bufs = flush || (start && state == ST_IDLE);
    assign load       = !clear_bufs && (bitcnt_p1 <= 7'd32) && (fifo_cnt_p0 != '0);

    assign outst_nxt    = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
    assign issued_nxt   = issued_q + 16'(gnt_fire);
    assign fifo_cnt_nxt = fifo_cnt_p0 + CW'(push) - CW'(load);
    // A slot is held by every FIFO entry and every granted-but-unanswered read.
    assign occ          = OW'(fifo_cnt_nxt) + OW'(outst_nxt);
    assign slots_ok     = occ < OW'(FIFO_DEPTH);

    always_comb begin
        state_nxt = state;
        req_nxt   = mem_req;
        addr_nxt  = mem_addr;
        error_nxt = error;
        latch_run = 1'b0;
        case (state)
            ST_IDLE: begin
                req_nxt = 1'b0;
                if (start) begin
                    latch_run = 1'b1;
                    error_nxt = 1'b0;
                    if (word_count != 16'd0) begin
                        state_nxt = ST_FETCH;
                        req_nxt   = 1'b1;
                        addr_nxt  = base_addr & ~ADDR_WIDTH'(3);
                    end
                end
            end
            ST_FETCH: begin
                if (flush || rsp_err) begin
                    state_nxt = (outst_nxt != '0 || hold_req) ? ST_DRAIN : ST_IDLE;
                    req_nxt   = hold_req;
                    if (rsp_err)
                        error_nxt = 1'b1;
                end else if (issued_nxt == total_q && outst_nxt == '0) begin
                    state_nxt = ST_IDLE;
                    req_nxt   = 1'b0;
                end else if (!hold_req) begin
                    req_nxt = (issued_nxt < total_q) && slots_ok;
                    if (req_nxt)
                        addr_nxt = word_addr(base_q, issued_nxt);
                end
            end
            ST_DRAIN: begin
                // An ungranted request stays up; its response is discarded later.
                req_nxt = hold_req;
                if (outst_nxt == '0 && !hold_req)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            error    <= 1'b0;
            base_q   <= '0;
            total_q  <= '0;
            issued_q <= '0;
            outst_q  <= '0;
        end else begin
            state    <= state_nxt;
            mem_req  <= req_nxt;
            mem_addr <= addr_nxt;
            error    <= error_nxt;
            outst_q  <= outst_nxt;
            if (latch_run) begin
                base_q   <= base_addr & ~ADDR_WIDTH'(3);
                total_q  <= word_count;
                issued_q <= '0;
            end else begin
                issued_q <= issued_nxt;
            end
        end
    end

    // Stage p0: response words into the prefetch FIFO
    always_ff @(posedge aclk) begin
        if (push)
            fifo_mem_p0[wr_ptr_p0] <= mem_rsp_rdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_p0   <= '0;
            rd_ptr_p0   <= '0;
            fifo_cnt_p0 <= '0;
        end else if (clear_bufs) begin
            wr_ptr_p0   <= '0;
            rd_ptr_p0   <= '0;
            fifo_cnt_p0 <= '0;
        end else begin
            if (push)
                wr_ptr_p0 <= wr_ptr_p0 + PW'(1);
            if (load)
                rd_ptr_p0 <= rd_ptr_p0 + PW'(1);
            fifo_cnt_p0 <= fifo_cnt_nxt;
        end
    end

    // Stage p1: left-aligned bit buffer; consume first, then place the new word below what remains
    always_comb begin
        consume   = field_req && vld_p1;
        cnt_after = consume ? (bitcnt_p1 - {2'b00, field_width}) : bitcnt_p1;
        buf_after = consume ? (bitbuf_p1 << field_width) : bitbuf_p1;
        load_word = fifo_mem_p0[rd_ptr_p0];
        buf_nxt   = buf_after;
        cnt_nxt   = cnt_after;
        if (load) begin
            buf_nxt = buf_after | ({load_word, 32'd0} >> cnt_after);
            cnt_nxt = cnt_after + 7'd32;
        end
        if (clear_bufs) begin
            buf_nxt = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bitbuf_p1 <= '0;
            bitcnt_p1 <= '0;
        end else begin
            bitbuf_p1 <= buf_nxt;
            bitcnt_p1 <= cnt_nxt;
        end
    end

    assign vld_p1      = (field_width != 5'd0) && (field_width <= 5'd16) &&
                         ({2'b00, field_width} <= bitcnt_p1);
    assign field_ready = vld_p1;
    assign field_data  = extract_field(bitbuf_p1[63:48], field_width);

endmodule
